// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the ID-stage hazard controller: forward selects and FSM states.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_EX      = 2'b01;
    localparam logic [1:0] FWD_MEMALU  = 2'b10;
    localparam logic [1:0] FWD_MEMDATA = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_LDSTALL = 2'b01,
        ST_FLUSH   = 2'b10,
        ST_HOLD    = 2'b11
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Operand forward select for one ID source operand from the EX/MEM shadow state.
module hazard_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] idx,
    input  logic              use_op,
    input  logic              ex_wreg,
    input  logic              ex_m2reg,
    input  logic [REG_AW-1:0] ex_destr,
    input  logic              mem_wreg,
    input  logic              mem_m2reg,
    input  logic [REG_AW-1:0] mem_destr,
    output logic [1:0]        sel
);

    // A load in EX cannot forward yet; it falls through so MEM may still match.
    always_comb begin
        sel = FWD_RF;
        if (use_op && (idx != '0)) begin
            if (ex_wreg && !ex_m2reg && (idx == ex_destr)) begin
                sel = FWD_EX;
            end else if (mem_wreg && (idx == mem_destr)) begin
                sel = mem_m2reg ? FWD_MEMDATA : FWD_MEMALU;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage hazard controller: forwarding, load-use stall, redirect flush, memory hold.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_destR,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic              id_redirect,
    input  logic              mem_hold,
    output logic [1:0]        fwda,
    output logic [1:0]        fwdb,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    state_e            state_q, state_d;
    logic              ex_wreg_q, ex_wreg_d, ex_m2reg_q, ex_m2reg_d;
    logic              mem_wreg_q, mem_wreg_d, mem_m2reg_q, mem_m2reg_d;
    logic [REG_AW-1:0] ex_destr_q, ex_destr_d, mem_destr_q, mem_destr_d;
    logic              load_use;

    assign load_use = id_valid && ex_wreg_q && ex_m2reg_q && (ex_destr_q != '0) &&
                      ((id_use_rs && (id_rs == ex_destr_q)) ||
                       (id_use_rt && (id_rt == ex_destr_q)));

    // Outputs act on the current cycle's hazards; state_q only records the decision.
    always_comb begin
        state_d     = ST_RUN;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (mem_hold) begin
            state_d = ST_HOLD;
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else if (load_use) begin
            state_d     = ST_LDSTALL;
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_redirect) begin
            state_d    = ST_FLUSH;
            ifid_flush = 1'b1;
        end
    end

    always_comb begin
        ex_wreg_d   = ex_wreg_q;
        ex_m2reg_d  = ex_m2reg_q;
        ex_destr_d  = ex_destr_q;
        mem_wreg_d  = mem_wreg_q;
        mem_m2reg_d = mem_m2reg_q;
        mem_destr_d = mem_destr_q;
        if (!mem_hold) begin
            mem_wreg_d  = ex_wreg_q;
            mem_m2reg_d = ex_m2reg_q;
            mem_destr_d = ex_destr_q;
            ex_wreg_d   = id_wreg && id_valid && !idex_bubble;
            ex_m2reg_d  = id_m2reg;
            ex_destr_d  = id_destR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            ex_wreg_q   <= 1'b0;
            ex_m2reg_q  <= 1'b0;
            ex_destr_q  <= '0;
            mem_wreg_q  <= 1'b0;
            mem_m2reg_q <= 1'b0;
            mem_destr_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_wreg_q   <= ex_wreg_d;
            ex_m2reg_q  <= ex_m2reg_d;
            ex_destr_q  <= ex_destr_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_m2reg_q <= mem_m2reg_d;
            mem_destr_q <= mem_destr_d;
        end
    end

    assign state = state_q;

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .idx(id_rs), .use_op(id_use_rs),
        .ex_wreg(ex_wreg_q), .ex_m2reg(ex_m2reg_q), .ex_destr(ex_destr_q),
        .mem_wreg(mem_wreg_q), .mem_m2reg(mem_m2reg_q), .mem_destr(mem_destr_q),
        .sel(fwda)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .idx(id_rt), .use_op(id_use_rt),
        .ex_wreg(ex_wreg_q), .ex_m2reg(ex_m2reg_q), .ex_destr(ex_destr_q),
        .mem_wreg(mem_wreg_q), .mem_m2reg(mem_m2reg_q), .mem_destr(mem_destr_q),
        .sel(fwdb)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    // Bubble/flush already exclude HOLD cycles; counters saturate.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (idex_bubble && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (counter checks follow HAZARD_PERF_CNT_EN).
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_redirect, mem_hold;
    logic [4:0]  id_rs, id_rt, id_destR;
    logic [1:0]  fwda, fwdb, state;
    logic        pc_we, ifid_we, ifid_flush, idex_bubble;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_destR(id_destR),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_redirect(id_redirect),
        .mem_hold(mem_hold), .fwda(fwda), .fwdb(fwdb), .pc_we(pc_we),
        .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] cnt(input int unsigned n);
        return CNT_ON ? 32'(n) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dst,
                       input logic wr, input logic ld, input logic redir);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_destR = dst; id_wreg = wr; id_m2reg = ld; id_redirect = redir;
        #1;
    endtask

    task automatic bubble();
        put(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_ctl(input string tag, input logic pw, input logic fl, input logic bb);
        chk({tag, "_pc_we"}, 32'(pc_we), 32'(pw));
        chk({tag, "_ifid_we"}, 32'(ifid_we), 32'(pw));
        chk({tag, "_flush"}, 32'(ifid_flush), 32'(fl));
        chk({tag, "_bubble"}, 32'(idex_bubble), 32'(bb));
    endtask

    initial begin
        rst = 1'b0; mem_hold = 1'b0;
        bubble();
        tick(); tick();
        rst = 1'b1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_fwda", 32'(fwda), 32'd0);
        chk("rst_fwdb", 32'(fwdb), 32'd0);
        chk_ctl("rst", 1'b1, 1'b0, 1'b0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);

        // ALU chain: EX forward, MEM forward, EX priority over MEM
        put(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); tick();
        put(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0);
        chk("t1_fwda_ex", 32'(fwda), 32'd1);
        chk("t1_fwdb_rf", 32'(fwdb), 32'd0);
        chk_ctl("t1", 1'b1, 1'b0, 1'b0);
        tick();
        put(1, 5'd3, 5'd0, 1, 1, 5'd3, 1, 0, 0);
        chk("t1_fwda_mem", 32'(fwda), 32'd2);
        chk("t1_fwdb_r0", 32'(fwdb), 32'd0);
        tick();
        put(1, 5'd3, 5'd4, 1, 1, 5'd3, 1, 0, 0);
        chk("t1_fwda_ex2", 32'(fwda), 32'd1);
        chk("t1_fwdb_mem", 32'(fwdb), 32'd2);
        tick();
        put(1, 5'd3, 5'd0, 1, 0, 5'd9, 0, 0, 0);
        chk("t1_fwda_prio", 32'(fwda), 32'd1);
        tick(); bubble(); tick(); bubble(); tick();

        // load-use stall then MEM data forward
        put(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1, 0); tick();
        put(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0);
        chk_ctl("t2_stall", 1'b0, 1'b0, 1'b1);
        chk("t2_state_pre", 32'(state), 32'd0);
        tick();
        chk("t2_state", 32'(state), 32'd1);
        chk("t2_stall_cnt", stall_cnt, cnt(1));
        chk_ctl("t2_after", 1'b1, 1'b0, 1'b0);
        chk("t2_fwda", 32'(fwda), 32'd3);
        chk("t2_fwdb", 32'(fwdb), 32'd3);
        tick();
        chk("t2_state_run", 32'(state), 32'd0);

        // taken branch flush, back to back
        put(1, 5'd1, 5'd2, 1, 1, 5'd0, 0, 0, 1);
        chk_ctl("t3_flush", 1'b1, 1'b1, 1'b0);
        tick();
        chk("t3_state", 32'(state), 32'd2);
        chk("t3_flush_cnt", flush_cnt, cnt(1));
        put(1, 5'd5, 5'd6, 1, 1, 5'd0, 0, 0, 1);
        chk_ctl("t3_flush2", 1'b1, 1'b1, 1'b0);
        tick();
        chk("t3_flush_cnt2", flush_cnt, cnt(2));
        bubble(); tick(); bubble(); tick();
        chk("t3_state_run", 32'(state), 32'd0);

        // load then dependent taken branch: stall first, then flush
        put(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0); tick();
        put(1, 5'd2, 5'd0, 1, 1, 5'd0, 0, 0, 1);
        chk_ctl("t4_stall", 1'b0, 1'b0, 1'b1);
        tick();
        chk("t4_state_ld", 32'(state), 32'd1);
        chk("t4_stall_cnt", stall_cnt, cnt(2));
        chk_ctl("t4_flush", 1'b1, 1'b1, 1'b0);
        chk("t4_fwda", 32'(fwda), 32'd3);
        tick();
        chk("t4_state_fl", 32'(state), 32'd2);
        chk("t4_flush_cnt", flush_cnt, cnt(3));
        bubble(); tick(); bubble(); tick();

        // memory hold over a load-use, then the stall
        put(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1, 0); tick();
        mem_hold = 1'b1;
        put(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0);
        chk_ctl("t5_hold", 1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        chk("t5_state_hold", 32'(state), 32'd3);
        chk("t5_stall_frozen", stall_cnt, cnt(2));
        chk("t5_flush_frozen", flush_cnt, cnt(3));
        mem_hold = 1'b0; #1;
        chk_ctl("t5_stall", 1'b0, 1'b0, 1'b1);
        tick();
        chk("t5_state_ld", 32'(state), 32'd1);
        chk("t5_stall_cnt", stall_cnt, cnt(3));
        chk("t5_fwda", 32'(fwda), 32'd3);
        tick(); bubble(); tick(); bubble(); tick();

        // r0 never forwarded or stalled on
        put(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0); tick();
        put(1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0);
        chk("t6_fwda_r0", 32'(fwda), 32'd0);
        chk("t6_fwdb_r0", 32'(fwdb), 32'd0);
        tick();
        put(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0, 0);
        chk_ctl("t6_nostall", 1'b1, 1'b0, 1'b0);
        chk("t6_fwda_mem_r0", 32'(fwda), 32'd0);
        tick();

        // reset during a load-use stall
        put(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0); tick();
        put(1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 0);
        chk("t6_pre_bubble", 32'(idex_bubble), 32'd1);
        rst = 1'b0;
        tick();
        chk("t6_rst_state", 32'(state), 32'd0);
        chk("t6_rst_fwda", 32'(fwda), 32'd0);
        chk_ctl("t6_rst", 1'b1, 1'b0, 1'b0);
        chk("t6_rst_stall_cnt", stall_cnt, 32'd0);
        chk("t6_rst_flush_cnt", flush_cnt, 32'd0);
        rst = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
